// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: fetches 2x-upscaled RGB565 frame-buffer pixels for the VGA timing stream
// and keeps sync/blank aligned with the returning read data.
module vga_pixel_fetch #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       pixel_x,
  input  logic [11:0]       pixel_y,
  input  logic              video_on_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              test_pattern,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [15:0]       rd_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start
);
  logic [11:0]       ax_q, ay_q;
  logic              avid_q, ahs_q, avs_q;
  logic [ADDR_W-1:0] line_base_q, line_base_d, rd_addr_q, rd_addr_d;
  logic              rd_en_q;
  logic [RD_LAT:0]   dvid_q, dhs_q, dvs_q, dyz_q;
  logic [9:0]        dx_q [RD_LAT+1];
  logic [7:0]        r_q, g_q, b_q, r_d, g_d, b_d;
  logic              hs_q, vs_q, blank_q, fs_q, fs_d;
  logic              vid;
  logic [9:0]        dx;
  logic [2:0]        bar;

  // Bar index maps to RGB as r=~bar[1], g=~bar[2], b=~bar[0] (white..black order)
  always_comb begin
    line_base_d = ay_q >= 12'(2*SRC_H) ? '0
                : (avid_q && ax_q == 12'(2*SRC_W-1) && ay_q[0]) ? line_base_q + ADDR_W'(SRC_W)
                : line_base_q;
    rd_addr_d = line_base_q + ADDR_W'(ax_q >> 1);
    vid = dvid_q[RD_LAT];
    dx = dx_q[RD_LAT];
    bar = 3'(dx / 10'd80);
    r_d = !vid ? '0 : test_pattern ? {8{~bar[1]}} : {rd_data[15:11], rd_data[15:13]};
    g_d = !vid ? '0 : test_pattern ? {8{~bar[2]}} : {rd_data[10:5], rd_data[10:9]};
    b_d = !vid ? '0 : test_pattern ? {8{~bar[0]}} : {rd_data[4:0], rd_data[4:2]};
    fs_d = vid && dx == '0 && dyz_q[RD_LAT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_q <= '0;
      ay_q <= '0;
      avid_q <= 1'b0;
      ahs_q <= 1'b1;
      avs_q <= 1'b1;
      line_base_q <= '0;
      rd_addr_q <= '0;
      rd_en_q <= 1'b0;
      dvid_q <= '0;
      dhs_q <= '1;
      dvs_q <= '1;
      dyz_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) dx_q[i] <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      blank_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ax_q <= pixel_x;
      ay_q <= pixel_y;
      avid_q <= video_on_in;
      ahs_q <= hsync_in;
      avs_q <= vsync_in;
      line_base_q <= line_base_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q <= avid_q;
      // Index 0 is captured alongside rd_addr; index RD_LAT lines up with rd_data
      dvid_q <= {dvid_q[RD_LAT-1:0], avid_q};
      dhs_q <= {dhs_q[RD_LAT-1:0], ahs_q};
      dvs_q <= {dvs_q[RD_LAT-1:0], avs_q};
      dyz_q <= {dyz_q[RD_LAT-1:0], ay_q == '0};
      dx_q[0] <= ax_q[9:0];
      for (int i = 1; i <= RD_LAT; i++) dx_q[i] <= dx_q[i-1];
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      hs_q <= dhs_q[RD_LAT];
      vs_q <= dvs_q[RD_LAT];
      blank_q <= vid;
      fs_q <= fs_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign rd_en = rd_en_q;
  assign vga_r = r_q;
  assign vga_g = g_q;
  assign vga_b = b_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_blank_n = blank_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed checks of vga_pixel_fetch at RD_LAT 1, 2 and 4 sharing one
// compressed timing stream; the RD_LAT=2 instance carries the address/data/pattern checks.
module tb_vga_pixel_fetch;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [11:0] px = '0, py = '0;
  logic von = 1'b0, hs = 1'b1, vs = 1'b1, tp = 1'b0;
  logic [16:0] addr1, addr2, addr4;
  logic en1, en2, en4;
  logic [15:0] d1, d2, d4;
  logic [7:0] r1, g1, b1, r2, g2, b2, r4, g4, b4;
  logic hs1, hs2, hs4, vs1, vs2, vs4, bl1, bl2, bl4, fs1, fs2, fs4;
  logic [16:0] p1_q [1];
  logic [16:0] p2_q [2];
  logic [16:0] p4_q [4];
  int nvec = 0, nerr = 0, en_cnt = 0, fs_cnt = 0;
  int l1, l2, l4;

  always #5 clk = ~clk;

  // Frame-buffer contents: word chosen by the low two address bits
  function automatic logic [15:0] fb(input logic [16:0] a);
    return a[1:0] == 2'd0 ? 16'hF800 : a[1:0] == 2'd1 ? 16'h07E0 :
           a[1:0] == 2'd2 ? 16'h001F : 16'h8410;
  endfunction

  always @(posedge clk) begin
    p1_q[0] <= addr1;
    p2_q[0] <= addr2;
    p2_q[1] <= p2_q[0];
    p4_q[0] <= addr4;
    for (int i = 1; i < 4; i++) p4_q[i] <= p4_q[i-1];
  end
  assign d1 = fb(p1_q[0]);
  assign d2 = fb(p2_q[1]);
  assign d4 = fb(p4_q[3]);

  vga_pixel_fetch #(.RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .pixel_x(px), .pixel_y(py), .video_on_in(von),
    .hsync_in(hs), .vsync_in(vs), .test_pattern(tp), .rd_addr(addr1), .rd_en(en1),
    .rd_data(d1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
    .vga_blank_n(bl1), .frame_start(fs1));
  vga_pixel_fetch #(.RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .pixel_x(px), .pixel_y(py), .video_on_in(von),
    .hsync_in(hs), .vsync_in(vs), .test_pattern(tp), .rd_addr(addr2), .rd_en(en2),
    .rd_data(d2), .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2),
    .vga_blank_n(bl2), .frame_start(fs2));
  vga_pixel_fetch #(.RD_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .pixel_x(px), .pixel_y(py), .video_on_in(von),
    .hsync_in(hs), .vsync_in(vs), .test_pattern(tp), .rd_addr(addr4), .rd_en(en4),
    .rd_data(d4), .vga_r(r4), .vga_g(g4), .vga_b(b4), .vga_hs(hs4), .vga_vs(vs4),
    .vga_blank_n(bl4), .frame_start(fs4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input int x, input int y);
    px = 12'(x);
    py = 12'(y);
    von = x < 640 && y < 480;
    hs = !(x >= 656 && x < 752);
    vs = !(y >= 490 && y < 492);
  endtask

  // Present (x,y) for n clocks, tallying rd_en and frame_start of the RD_LAT=2 instance
  task automatic drive(input int x, input int y, input int n);
    set(x, y);
    repeat (n) begin
      @(negedge clk);
      if (en2) en_cnt++;
      if (fs2) fs_cnt++;
    end
  endtask

  function automatic logic sel(input int s, input int d);
    if (s == 0) return d == 0 ? bl1 : d == 1 ? bl2 : bl4;
    if (s == 1) return d == 0 ? hs1 : d == 1 ? hs2 : hs4;
    return d == 0 ? vs1 : d == 1 ? vs2 : vs4;
  endfunction

  // Clocks from the edge that samples the new input until the output changes (-1: never)
  task automatic meas(input int s, output int o1, output int o2, output int o4);
    logic v1, v2, v4;
    v1 = sel(s, 0);
    v2 = sel(s, 1);
    v4 = sel(s, 2);
    o1 = -1;
    o2 = -1;
    o4 = -1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (o1 < 0 && sel(s, 0) !== v1) o1 = k;
      if (o2 < 0 && sel(s, 1) !== v2) o2 = k;
      if (o4 < 0 && sel(s, 2) !== v4) o4 = k;
    end
    @(negedge clk);
  endtask

  initial begin
    set(700, 490);
    repeat (3) @(negedge clk);
    chk("rst_rd_addr", 32'(addr2), 0);
    chk("rst_rd_en", 32'(en2), 0);
    chk("rst_hs", 32'(hs2), 1);
    chk("rst_vs", 32'(vs2), 1);
    chk("rst_blank_n", 32'(bl2), 0);
    chk("rst_r", 32'(r2), 0);
    chk("rst_fs", 32'(fs2), 0);
    rst_n = 1'b1;
    drive(640, 0, 4);
    drive(0, 0, 8);
    chk("a00_addr", 32'(addr2), 0);
    chk("a00_en", 32'(en2), 1);
    chk("a00_blank", 32'(bl2), 1);
    chk("a00_fs", 32'(fs2), 1);
    chk("d_F800", {8'h0, r2, g2, b2}, 32'hFF0000);
    drive(2, 0, 8);
    chk("d_07E0", {8'h0, r2, g2, b2}, 32'h00FF00);
    chk("a20_fs", 32'(fs2), 0);
    drive(4, 0, 8);
    chk("d_001F", {8'h0, r2, g2, b2}, 32'h0000FF);
    drive(6, 0, 8);
    chk("d_8410", {8'h0, r2, g2, b2}, 32'h848284);
    drive(639, 0, 8);
    chk("a639_0", 32'(addr2), 319);
    drive(0, 1, 8);
    chk("a0_1", 32'(addr2), 0);
    drive(639, 1, 1);
    drive(700, 1, 8);
    drive(0, 2, 8);
    chk("a0_2", 32'(addr2), 320);
    drive(639, 2, 8);
    chk("a639_2", 32'(addr2), 639);
    drive(700, 2, 8);
    en_cnt = 0;
    for (int y = 3; y < 479; y++) begin
      drive(0, y, 1);
      drive(639, y, 1);
      drive(700, y, 1);
    end
    drive(0, 479, 1);
    drive(639, 479, 1);
    drive(700, 479, 1);
    chk("a639_479", 32'(addr2), 76799);
    drive(700, 479, 8);
    chk("rd_en_count", 32'(en_cnt), 954);
    drive(0, 480, 8);
    chk("y480_blank", 32'(bl2), 0);
    chk("y480_en", 32'(en2), 0);
    drive(700, 524, 8);
    drive(0, 0, 8);
    chk("next_frame_a00", 32'(addr2), 0);
    drive(700, 0, 8);
    fs_cnt = 0;
    for (int x = 0; x < 16; x++) drive(x, 0, 1);
    drive(700, 0, 10);
    chk("fs_pulses", 32'(fs_cnt), 1);
    tp = 1'b1;
    drive(0, 0, 8);
    chk("tp_white", {8'h0, r2, g2, b2}, 32'hFFFFFF);
    drive(80, 0, 8);
    chk("tp_yellow", {8'h0, r2, g2, b2}, 32'hFFFF00);
    drive(200, 0, 8);
    chk("tp_cyan", {8'h0, r2, g2, b2}, 32'h00FFFF);
    drive(560, 0, 8);
    chk("tp_black", {8'h0, r2, g2, b2}, 32'h000000);
    chk("tp_black_blank", 32'(bl2), 1);
    drive(640, 0, 8);
    chk("tp_blanked", {7'h0, bl2, r2, g2, b2}, 32'h0);
    tp = 1'b0;
    drive(700, 10, 10);
    set(0, 10);
    meas(0, l1, l2, l4);
    chk("lat_blank_L1", 32'(l1), 3);
    chk("lat_blank_L2", 32'(l2), 4);
    chk("lat_blank_L4", 32'(l4), 6);
    drive(600, 10, 10);
    set(656, 10);
    meas(1, l1, l2, l4);
    chk("lat_hs_L1", 32'(l1), 3);
    chk("lat_hs_L2", 32'(l2), 4);
    chk("lat_hs_L4", 32'(l4), 6);
    drive(0, 489, 10);
    set(0, 490);
    meas(2, l1, l2, l4);
    chk("lat_vs_L1", 32'(l1), 3);
    chk("lat_vs_L2", 32'(l2), 4);
    chk("lat_vs_L4", 32'(l4), 6);
    drive(700, 524, 8);
    for (int y = 0; y < 200; y++) begin
      drive(0, y, 1);
      drive(639, y, 1);
      drive(700, y, 1);
    end
    drive(100, 200, 8);
    chk("pre_rst_addr", 32'(addr2), 32050);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_blank", 32'(bl2), 0);
    chk("arst_en", 32'(en2), 0);
    chk("arst_addr", 32'(addr2), 0);
    chk("arst_b", 32'(b2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 200, 8);
    chk("post_rst_addr", 32'(addr2), 0);
    for (int y = 201; y < 480; y++) begin
      drive(0, y, 1);
      drive(639, y, 1);
      drive(700, y, 1);
    end
    drive(0, 480, 8);
    drive(700, 524, 8);
    drive(0, 0, 8);
    chk("rst_frame_a00", 32'(addr2), 0);
    drive(0, 1, 1);
    drive(639, 1, 1);
    drive(700, 1, 4);
    drive(0, 2, 8);
    chk("rst_frame_a0_2", 32'(addr2), 320);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
